i2c_target: RTL and testbench
=============================

# i2c_target

Byte-level I2C target (responder) that answers a bus master at a fixed 7-bit address. It oversamples SCL/SDA on the system clock, detects START/STOP, and shifts address and data bits. It ACKs its own address and all written bytes, and serves read bytes from a local byte-request handshake. It sits opposite the team's I2C master interface on the same two-wire bus. It is the device-side endpoint for register banks and bring-up loopback.

## Interface
Parameters:
- `ADDR`, 7'h50, own 7-bit target address.
- `SYNC_STAGES`, 2, synchronizer depth on `scl_i`/`sda_i` (≥2).

Ports:
- `clk`  in  1  system clock; must be ≥ 8× SCL frequency.
- `rst_a`  in  1  reset, asynchronous, active-high.
- `scl_i`  in  1  raw SCL pin level (target never drives SCL; no clock stretching).
- `sda_i`  in  1  raw SDA pin level.
- `sda_oe`  out  1  1 = pull SDA low; 0 = release (open-drain, top level builds the tristate).
- `rx_data`  out  8  last byte written by master.
- `rx_valid`  out  1  one-cycle pulse, `rx_data` new.
- `tx_req`  out  1  one-cycle pulse, target needs next read byte.
- `tx_data`  in  8  read byte, sampled exactly 1 clk after `tx_req`.
- `start_det`  out  1  one-cycle pulse on START or repeated START.
- `stop_det`  out  1  one-cycle pulse on STOP.
- `busy`  out  1  1 from START until STOP.

## Operation
- Line conditioning: `scl_i`/`sda_i` pass through `SYNC_STAGES` flops, then one history flop. All events use synchronized `scl_s`/`sda_s`.
- START: `sda_s` 1→0 while `scl_s`=1. STOP: `sda_s` 0→1 while `scl_s`=1. Both take priority over every state and any bit activity in the same cycle.
- Bits sampled on `scl_s` rising edge. `sda_oe` changes only on the cycle after the `scl_s` falling edge is detected.
- Bit counter 0..7, MSB first. Reset to 0 on START and on entering each byte state.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits. On the 8th rise, if bits[7:1]==`ADDR` → ADDR_ACK, else → WAIT_STOP.
  - ADDR_ACK: drive `sda_oe`=1 for the 9th SCL period. On the following fall: R/W=0 → WRITE; R/W=1 → pulse `tx_req`, load `tx_data` next clk, → READ.
  - WRITE: shift 8 bits. On the 8th rise, update `rx_data` and pulse `rx_valid` → WRITE_ACK.
  - WRITE_ACK: drive ACK for the 9th period, then → WRITE.
  - READ: `sda_oe` = ~shift[7] for each bit, shifting on falls. After the 8th fall, release SDA → READ_ACK.
  - READ_ACK: sample master bit on the 9th rise. 0 (ACK): pulse `tx_req` on the next fall, reload, → READ. 1 (NACK) → WAIT_STOP.
  - WAIT_STOP: `sda_oe`=0, ignore bits until START/STOP.
- START in any state → ADDR (repeated START), `start_det` pulse, `busy`=1, `sda_oe` released the same cycle.
- STOP in any state → IDLE, `stop_det` pulse, `busy`=0, `sda_oe`=0.
- General-call address (0x00) is not acknowledged.

## Timing
- Reset values:
  - `sda_oe`=0, `rx_data`=8'h00, `rx_valid`=0, `tx_req`=0, `start_det`=0, `stop_det`=0, `busy`=0.
  - state IDLE, bit counter 0, shift register 8'h00.
- Pin-to-event latency: `SYNC_STAGES`+1 clk (3 clk at default).
- `sda_oe` update: `SYNC_STAGES`+2 clk after the physical SCL fall. The clock ratio guarantees this completes within the SCL low phase.
- `rx_valid`: same cycle the 8th rise is detected. `tx_req` → `tx_data` sample: exactly 1 clk.
- Reset asserted mid-transfer releases SDA immediately (async). After release, the target ignores the bus until a fresh START.

## Structure
- Package `i2c_pkg`: state enum `i2c_tgt_state_t` (IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, WAIT_STOP), `I2C_RW_READ`=1'b1, bit-count width constant.
- Sub-module `i2c_line_sync`: per-line synchronizer plus rise/fall pulse outputs, instantiated for SCL and SDA.

## Test plan
- Write 0xA0 (addr 0x50, W), byte 0x3C, STOP → ACK on both 9th clocks, `rx_data`=0x3C with one `rx_valid`, `stop_det` pulse, `busy`=0.
- Address 0x51 write → no ACK (`sda_oe` stays 0 whole frame), no `rx_valid`, IDLE after STOP.
- Read 0xA1, `tx_data`=0x96 then 0x5A, master ACK then NACK → bus carries 0x96,0x5A. Two `tx_req` pulses, SDA released after the NACK.
- Write 0xA0, byte 0x11, repeated START, 0xA1 read → `start_det` twice, `rx_valid` once, `tx_req` after the second address ACK.
- STOP injected at bit 4 of a write → `stop_det`, `sda_oe`=0, no `rx_valid`. The next START+0xA0 is ACKed normally.
- `rst_a` pulsed while driving ACK → `sda_oe`=0 within the reset cycle, all outputs at reset values.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the byte-level I2C target.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WRITE,
    ST_WRITE_ACK,
    ST_READ,
    ST_READ_ACK,
    ST_WAIT_STOP
  } i2c_tgt_state_t;

  localparam logic I2C_RW_READ = 1'b1;
  localparam int unsigned I2C_BIT_CNT_W = 3;
  localparam logic [I2C_BIT_CNT_W-1:0] I2C_BIT_LAST = '1;

endpackage

// File: rtl/i2c_target_if.sv
// Pin and byte-handshake bundle between the I2C target and its surroundings.
interface i2c_target_if;
  logic       scl_i;
  logic       sda_i;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_req;
  logic [7:0] tx_data;
  logic       start_det;
  logic       stop_det;
  logic       busy;

  modport slave (
    input  scl_i, sda_i, tx_data,
    output sda_oe, rx_data, rx_valid, tx_req, start_det, stop_det, busy
  );

  modport master (
    output scl_i, sda_i, tx_data,
    input  sda_oe, rx_data, rx_valid, tx_req, start_det, stop_det, busy
  );
endinterface

// File: rtl/i2c_line_sync.sv
// Multi-flop synchronizer for one bus line plus a history flop giving edge pulses.
module i2c_line_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_a,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              hist;

  // Idle bus level is high, so reset to 1 to avoid phantom edges.
  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      sync <= '1;
      hist <= 1'b1;
    end else begin
      sync <= {sync[STAGES-2:0], d};
      hist <= sync[STAGES-1];
    end
  end

  assign q    = sync[STAGES-1];
  assign rise = q & ~hist;
  assign fall = ~q & hist;

endmodule

// File: rtl/i2c_target.sv
// I2C target at a fixed 7-bit address: ACKs address and written bytes, serves reads via tx_req.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0]  ADDR        = 7'h50,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_a,
  i2c_target_if.slave  bus
);

  logic scl_s, scl_rise, scl_fall;
  logic sda_s, sda_rise, sda_fall;

  i2c_line_sync #(.STAGES(SYNC_STAGES)) u_scl_sync (
    .clk (clk), .rst_a (rst_a), .d (bus.scl_i),
    .q (scl_s), .rise (scl_rise), .fall (scl_fall)
  );

  i2c_line_sync #(.STAGES(SYNC_STAGES)) u_sda_sync (
    .clk (clk), .rst_a (rst_a), .d (bus.sda_i),
    .q (sda_s), .rise (sda_rise), .fall (sda_fall)
  );

  i2c_tgt_state_t             state;
  logic [I2C_BIT_CNT_W-1:0]   bit_cnt;
  logic [7:0]                 shift;
  logic                       ack_clk;
  logic                       fall_d;
  logic                       sda_oe_q;
  logic [7:0]                 rx_data_q;
  logic                       rx_valid_q;
  logic                       tx_req_q;
  logic                       start_q;
  logic                       stop_q;
  logic                       busy_q;

  logic       start_cond, stop_cond, addr_hit, oe_next;
  logic [7:0] shift_in;

  assign start_cond = sda_fall & scl_s;
  assign stop_cond  = sda_rise & scl_s;
  assign shift_in   = {shift[6:0], sda_s};
  assign addr_hit   = (shift[6:0] == ADDR) && (ADDR != 7'h00);

  // A just-requested read byte is still on tx_data when SDA is updated, so drive its MSB directly.
  always_comb begin
    oe_next = 1'b0;
    unique case (state)
      ST_ADDR_ACK, ST_WRITE_ACK: oe_next = 1'b1;
      ST_READ:                   oe_next = ~(tx_req_q ? bus.tx_data[7] : shift[7]);
      default:                   oe_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      ack_clk    <= 1'b0;
      fall_d     <= 1'b0;
      sda_oe_q   <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      fall_d     <= scl_fall;

      if (tx_req_q) shift <= bus.tx_data;
      if (fall_d)   sda_oe_q <= oe_next;

      if (start_cond) begin
        state    <= ST_ADDR;
        bit_cnt  <= '0;
        ack_clk  <= 1'b0;
        start_q  <= 1'b1;
        busy_q   <= 1'b1;
        sda_oe_q <= 1'b0;
      end else if (stop_cond) begin
        state    <= ST_IDLE;
        bit_cnt  <= '0;
        ack_clk  <= 1'b0;
        stop_q   <= 1'b1;
        busy_q   <= 1'b0;
        sda_oe_q <= 1'b0;
      end else begin
        unique case (state)
          ST_ADDR: if (scl_rise) begin
            shift <= shift_in;
            if (bit_cnt == I2C_BIT_LAST) begin
              bit_cnt <= '0;
              ack_clk <= 1'b0;
              state   <= addr_hit ? ST_ADDR_ACK : ST_WAIT_STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          ST_ADDR_ACK: begin
            if (scl_rise) begin
              ack_clk <= 1'b1;
            end else if (scl_fall && ack_clk) begin
              ack_clk <= 1'b0;
              bit_cnt <= '0;
              if (shift[0] == I2C_RW_READ) begin
                tx_req_q <= 1'b1;
                state    <= ST_READ;
              end else begin
                state    <= ST_WRITE;
              end
            end
          end
          ST_WRITE: if (scl_rise) begin
            shift <= shift_in;
            if (bit_cnt == I2C_BIT_LAST) begin
              rx_data_q  <= shift_in;
              rx_valid_q <= 1'b1;
              bit_cnt    <= '0;
              ack_clk    <= 1'b0;
              state      <= ST_WRITE_ACK;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          ST_WRITE_ACK: begin
            if (scl_rise) begin
              ack_clk <= 1'b1;
            end else if (scl_fall && ack_clk) begin
              ack_clk <= 1'b0;
              bit_cnt <= '0;
              state   <= ST_WRITE;
            end
          end
          ST_READ: if (scl_fall) begin
            if (bit_cnt == I2C_BIT_LAST) begin
              bit_cnt <= '0;
              ack_clk <= 1'b0;
              state   <= ST_READ_ACK;
            end else begin
              shift   <= {shift[6:0], 1'b0};
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          ST_READ_ACK: begin
            if (scl_rise) begin
              if (!sda_s) ack_clk <= 1'b1;
              else        state   <= ST_WAIT_STOP;
            end else if (scl_fall && ack_clk) begin
              ack_clk  <= 1'b0;
              bit_cnt  <= '0;
              tx_req_q <= 1'b1;
              state    <= ST_READ;
            end
          end
          ST_IDLE, ST_WAIT_STOP: ;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.sda_oe    = sda_oe_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.tx_req    = tx_req_q;
  assign bus.start_det = start_q;
  assign bus.stop_det  = stop_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench acting as I2C master against i2c_target, with a transaction-level expectation model.
module tb_i2c_target;

  localparam int unsigned Q   = 8;
  localparam logic [6:0]  TGT = 7'h50;

  logic clk = 1'b0;
  logic rst_a;
  always #5 clk = ~clk;

  i2c_target_if bus ();

  logic       scl_m, sda_m;
  logic [7:0] tx_cur = 8'h00;

  assign bus.scl_i   = scl_m;
  assign bus.sda_i   = sda_m & ~bus.sda_oe;
  assign bus.tx_data = tx_cur;

  i2c_target #(.ADDR(TGT), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .rst_a (rst_a),
    .bus   (bus)
  );

  int unsigned vectors = 0, miscompares = 0;
  int unsigned n_start = 0, n_stop = 0, n_txreq = 0;
  int unsigned exp_start = 0, exp_stop = 0, exp_txreq = 0;
  logic [7:0]  exp_rx_q[$];
  logic [7:0]  tx_src_q[$];
  logic [7:0]  data_q[$];
  bit chk_busy = 0, m_busy = 0, m_silent = 0, pop_pend = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle monitor: read-byte provider, event counting and model comparisons.
  always @(negedge clk) begin
    if (pop_pend) begin
      if (tx_src_q.size() > 0) tx_src_q.delete(0);
      pop_pend = 0;
    end
    if (bus.tx_req) begin
      pop_pend = 1;
      n_txreq++;
    end
    tx_cur = (tx_src_q.size() > 0) ? tx_src_q[0] : 8'h00;
    if (bus.start_det) n_start++;
    if (bus.stop_det)  n_stop++;
    if (bus.rx_valid) begin
      if (exp_rx_q.size() == 0) check("rx_valid_unexpected", bus.rx_valid, 0);
      else                      check("rx_data", bus.rx_data, exp_rx_q.pop_front());
    end
    if (chk_busy && !rst_a) check("busy", bus.busy, m_busy);
    if (m_silent)           check("sda_oe_silent", bus.sda_oe, 0);
  end

  task automatic wq();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic m_start();
    chk_busy = 0; m_silent = 0;
    sda_m = 1'b1; wq();
    scl_m = 1'b1; wq();
    sda_m = 1'b0; exp_start++; wq();
    m_busy = 1; chk_busy = 1;
    scl_m = 1'b0;
  endtask

  task automatic m_stop();
    chk_busy = 0;
    wq(); sda_m = 1'b0;
    wq(); scl_m = 1'b1;
    wq(); sda_m = 1'b1; exp_stop++;
    wq();
    m_busy = 0; chk_busy = 1; m_silent = 1;
  endtask

  task automatic clock_bit(input logic b, output logic s);
    wq(); sda_m = b;
    wq(); scl_m = 1'b1;
    wq(); s = bus.sda_i;
    wq(); scl_m = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(d[i], s);
    clock_bit(1'b1, s);
    acked = ~s;
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s);
      d[i] = s;
    end
    clock_bit(~mack, s);
  endtask

  function automatic logic [7:0] next_byte();
    if (data_q.size() > 0) return data_q.pop_front();
    return 8'($urandom);
  endfunction

  // One addressed frame (START or repeated START, address, n bytes); the caller ends it.
  task automatic do_frame(input logic [7:0] abyte, input int unsigned n);
    logic       ack;
    logic [7:0] d, rb;
    logic [7:0] exp_rd[$];
    bit         hit;
    hit = (abyte[7:1] == TGT);
    m_start();
    m_silent = !hit;
    write_byte(abyte, ack);
    check("addr_ack", ack, hit);
    if (abyte[0] == 1'b0) begin
      for (int unsigned i = 0; i < n; i++) begin
        d = next_byte();
        if (hit) exp_rx_q.push_back(d);
        write_byte(d, ack);
        check("data_ack", ack, hit);
      end
    end else begin
      for (int unsigned i = 0; i < n; i++) begin
        d = next_byte();
        exp_rd.push_back(hit ? d : 8'hFF);
        if (hit) tx_src_q.push_back(d);
      end
      if (hit) exp_txreq += n;
      for (int unsigned i = 0; i < n; i++) begin
        read_byte(i != n - 1, rb);
        check("read_data", rb, exp_rd[i]);
      end
    end
  endtask

  task automatic check_counts();
    check("start_cnt", n_start, exp_start);
    check("stop_cnt", n_stop, exp_stop);
    check("tx_req_cnt", n_txreq, exp_txreq);
    check("rx_pending", exp_rx_q.size(), 0);
  endtask

  task automatic check_reset_outputs();
    check("rst_sda_oe", bus.sda_oe, 0);
    check("rst_rx_data", bus.rx_data, 8'h00);
    check("rst_rx_valid", bus.rx_valid, 0);
    check("rst_tx_req", bus.tx_req, 0);
    check("rst_start_det", bus.start_det, 0);
    check("rst_stop_det", bus.stop_det, 0);
    check("rst_busy", bus.busy, 0);
  endtask

  initial begin
    logic       ack, s, open;
    logic [7:0] abyte;
    scl_m = 1'b1; sda_m = 1'b1; rst_a = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs();
    rst_a = 1'b0;
    repeat (4) @(posedge clk);
    #1 m_busy = 0; chk_busy = 1; m_silent = 1;

    // Write 0x3C to the target.
    data_q.push_back(8'h3C);
    do_frame(8'hA0, 1);
    m_stop();
    check("wr_rx_data", bus.rx_data, 8'h3C);
    check_counts();

    // Foreign address 0x51 and general call: never acknowledged.
    do_frame(8'hA2, 1);
    m_stop();
    do_frame(8'h00, 1);
    m_stop();
    check_counts();

    // Read 0x96 then 0x5A, master ACK then NACK.
    data_q.push_back(8'h96);
    data_q.push_back(8'h5A);
    do_frame(8'hA1, 2);
    m_stop();
    check_counts();

    // Write followed by repeated START into a read.
    data_q.push_back(8'h11);
    do_frame(8'hA0, 1);
    do_frame(8'hA1, 1);
    m_stop();
    check("rs_rx_data", bus.rx_data, 8'h11);
    check_counts();

    // STOP in the middle of a data byte, then a normal write.
    m_start();
    write_byte(8'hA0, ack);
    check("abort_addr_ack", ack, 1);
    for (int i = 0; i < 4; i++) clock_bit(1'($urandom), s);
    m_stop();
    check("abort_sda_oe", bus.sda_oe, 0);
    do_frame(8'hA0, 1);
    m_stop();
    check_counts();

    // Reset while the address ACK is being driven.
    m_start();
    for (int i = 7; i >= 0; i--) clock_bit(abyte_a0(i), s);
    repeat (6) @(posedge clk);
    #1 check("ack_drive", bus.sda_oe, 1);
    chk_busy = 0;
    #2 rst_a = 1'b1;
    #1 check_reset_outputs();
    repeat (2) @(posedge clk);
    #1 rst_a = 1'b0;
    m_busy = 0; chk_busy = 1; m_silent = 1;
    m_stop();
    do_frame(8'hA0, 1);
    m_stop();
    check_counts();

    // Randomized traffic, sometimes chained with repeated START.
    open = 1'b0;
    for (int k = 0; k < 24; k++) begin
      abyte[7:1] = ($urandom_range(0, 2) != 0) ? TGT : 7'($urandom_range(0, 127));
      abyte[0]   = 1'($urandom);
      do_frame(abyte, $urandom_range(1, 3));
      open = 1'b1;
      if ($urandom_range(0, 3) != 0) begin
        m_stop();
        open = 1'b0;
      end
    end
    if (open) m_stop();
    repeat (8) @(posedge clk);
    #1 check_counts();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  function automatic logic abyte_a0(input int i);
    logic [7:0] a;
    a = 8'hA0;
    return a[i];
  endfunction

endmodule
